// File: rtl/fetch_pkg.sv
// Shared types and sizes for the instruction fetch buffer.
package fetch_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int INSN_WIDTH  = 32;
  localparam int FETCH_DEPTH = 4;
  localparam int INSN_SIZE   = 4;

  typedef logic [ADDR_WIDTH-1:2] Addr;
  typedef logic [INSN_WIDTH-1:0] Insn;

endpackage

// File: rtl/insn_fetch_buffer_if.sv
// Fetch buffer channels: pc in, imem req/resp, decode out.
interface insn_fetch_buffer_if;
  import fetch_pkg::*;

  logic pc_valid;
  Addr  pc_addr;
  logic pc_ready;
  logic mem_req_valid;
  Addr  mem_req_addr;
  logic mem_req_ready;
  logic mem_resp_valid;
  Insn  mem_resp_data;
  logic flush;
  logic insn_valid;
  Insn  insn_data;
  Addr  insn_addr;
  logic insn_ready;
  logic resp_err;

  modport slave (
    input  pc_valid, pc_addr,
    input  mem_req_ready,
    input  mem_resp_valid, mem_resp_data,
    input  flush, insn_ready,
    output pc_ready,
    output mem_req_valid, mem_req_addr,
    output insn_valid, insn_data, insn_addr,
    output resp_err
  );

  modport master (
    output pc_valid, pc_addr,
    output mem_req_ready,
    output mem_resp_valid, mem_resp_data,
    output flush, insn_ready,
    input  pc_ready,
    input  mem_req_valid, mem_req_addr,
    input  insn_valid, insn_data, insn_addr,
    input  resp_err
  );

endinterface

// File: rtl/fetch_ring.sv
// Slot storage: address written at request, data at response.
module fetch_ring
  import fetch_pkg::*;
#(
  parameter  int DEPTH = FETCH_DEPTH,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wa_en,
  input  logic [IW-1:0] wa_idx,
  input  Addr           wa_addr,
  input  logic          wd_en,
  input  logic [IW-1:0] wd_idx,
  input  Insn           wd_data,
  input  logic [IW-1:0] rd_idx,
  output Addr           rd_addr,
  output Insn           rd_data
);

  Addr addr_q [DEPTH];
  Insn data_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (wa_en) addr_q[wa_idx] <= wa_addr;
      if (wd_en) data_q[wd_idx] <= wd_data;
    end
  end

  assign rd_addr = addr_q[rd_idx];
  assign rd_data = data_q[rd_idx];

endmodule

// File: rtl/insn_fetch_buffer.sv
// Fetch buffer: issues pc to imem, rings in-order responses to decode.
module insn_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input logic clk,
  input logic rst_n,
  insn_fetch_buffer_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int DW = $clog2(DEPTH + 1);

  logic [PW-1:0] alloc_q, fill_q, head_q;
  logic [DW-1:0] drop_q, drop_flush;
  logic          err_q;
  logic [PW:0]   credit;
  logic          has_credit;
  logic          req_fire, pop;
  logic          resp_drop, resp_fill, resp_orphan;
  logic          drop_nz, ring_busy;

  assign credit = (PW+1)'(DEPTH)
                - {1'b0, alloc_q - head_q}
                - (PW+1)'(drop_q);
  assign has_credit = credit != '0;

  assign bus.pc_ready      = bus.mem_req_ready & has_credit & ~bus.flush;
  assign bus.mem_req_valid = bus.pc_valid & has_credit & ~bus.flush;
  assign bus.mem_req_addr  = bus.pc_addr;
  assign req_fire          = bus.pc_valid & bus.pc_ready;

  assign drop_nz     = drop_q != '0;
  assign ring_busy   = fill_q != alloc_q;
  assign resp_drop   = bus.mem_resp_valid & drop_nz;
  assign resp_fill   = bus.mem_resp_valid & ~drop_nz & ring_busy;
  assign resp_orphan = bus.mem_resp_valid & ~drop_nz & ~ring_busy;

  assign bus.insn_valid = head_q != fill_q;
  assign pop = bus.insn_valid & bus.insn_ready & ~bus.flush;
  assign bus.resp_err = err_q;

  // Everything still in flight must be swallowed after a redirect.
  assign drop_flush = drop_q
                    + DW'(alloc_q - fill_q)
                    - DW'(resp_drop | resp_fill);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
      drop_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (resp_orphan) err_q <= 1'b1;
      if (bus.flush) begin
        alloc_q <= '0;
        fill_q  <= '0;
        head_q  <= '0;
        drop_q  <= drop_flush;
      end else begin
        if (req_fire)  alloc_q <= alloc_q + PW'(1);
        if (resp_fill) fill_q  <= fill_q + PW'(1);
        if (resp_drop) drop_q  <= drop_q - DW'(1);
        if (pop)       head_q  <= head_q + PW'(1);
      end
    end
  end

  fetch_ring #(.DEPTH(DEPTH)) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .wa_en   (req_fire),
    .wa_idx  (alloc_q[IW-1:0]),
    .wa_addr (bus.pc_addr),
    .wd_en   (resp_fill & ~bus.flush),
    .wd_idx  (fill_q[IW-1:0]),
    .wd_data (bus.mem_resp_data),
    .rd_idx  (head_q[IW-1:0]),
    .rd_addr (bus.insn_addr),
    .rd_data (bus.insn_data)
  );

endmodule

// File: tb/tb_insn_fetch_buffer.sv
// Random bench for insn_fetch_buffer against a queue-based model.
module tb_insn_fetch_buffer;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  insn_fetch_buffer_if bus();

  insn_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    Addr addr;
    Insn data;
    int  due;
  } mreq_t;

  typedef struct {
    Addr addr;
    Insn data;
  } ent_t;

  mreq_t mq[$];
  Addr   pend[$];
  ent_t  rdy[$];
  int    drop;
  bit    err;
  int    cyc;
  int    n_pass;
  int    n_checks;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    pend.delete();
    rdy.delete();
    drop = 0;
    err  = 1'b0;
  endtask

  task automatic step(bit pv, bit fl, bit spur, int rdy_pct);
    bit    resp;
    Insn   rdata;
    bit    exp_pr, exp_rv, exp_iv;
    bit    fire, pop;
    int    credit, used;
    mreq_t m;
    ent_t  e;
    @(negedge clk);
    bus.pc_valid      = pv;
    bus.pc_addr       = Addr'($urandom);
    bus.mem_req_ready = $urandom_range(0, 3) != 0;
    bus.insn_ready    = $urandom_range(0, 99) < rdy_pct;
    bus.flush         = fl;
    resp  = 1'b0;
    rdata = Insn'($urandom);
    if (spur) begin
      resp = 1'b1;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      m     = mq.pop_front();
      resp  = 1'b1;
      rdata = m.data;
    end
    bus.mem_resp_valid = resp;
    bus.mem_resp_data  = rdata;
    #1;
    credit = DEPTH - pend.size() - rdy.size() - drop;
    exp_pr = bus.mem_req_ready && credit != 0 && !fl;
    exp_rv = pv && credit != 0 && !fl;
    exp_iv = rdy.size() != 0;
    check("pc_ready", bus.pc_ready, exp_pr);
    check("mem_req_valid", bus.mem_req_valid, exp_rv);
    if (exp_rv)
      check("mem_req_addr", bus.mem_req_addr, bus.pc_addr);
    check("insn_valid", bus.insn_valid, exp_iv);
    if (exp_iv) begin
      check("insn_addr", bus.insn_addr, rdy[0].addr);
      check("insn_data", bus.insn_data, rdy[0].data);
    end
    check("resp_err", bus.resp_err, err);
    fire = pv && exp_pr;
    pop  = exp_iv && bus.insn_ready && !fl;
    if (fl) begin
      used = resp ? 1 : 0;
      if (resp && drop == 0 && pend.size() == 0) begin
        err  = 1'b1;
        used = 0;
      end
      drop = drop + pend.size() - used;
      pend.delete();
      rdy.delete();
    end else begin
      if (resp) begin
        if (drop > 0) drop--;
        else if (pend.size() > 0) begin
          e.addr = pend.pop_front();
          e.data = rdata;
          rdy.push_back(e);
        end else err = 1'b1;
      end
      if (pop) void'(rdy.pop_front());
      if (fire) begin
        pend.push_back(bus.pc_addr);
        m.addr = bus.pc_addr;
        m.data = Insn'($urandom);
        m.due  = cyc + int'($urandom_range(1, 4));
        mq.push_back(m);
      end
    end
    cyc++;
  endtask

  initial begin
    int pct;
    n_pass   = 0;
    n_checks = 0;
    cyc      = 0;
    model_reset();
    bus.pc_valid       = 1'b1;
    bus.pc_addr        = Addr'(32'h100);
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    bus.flush          = 1'b0;
    bus.insn_ready     = 1'b0;
    #12;
    check("rst_pc_ready", bus.pc_ready, 1'b1);
    check("rst_req_valid", bus.mem_req_valid, 1'b1);
    check("rst_insn_valid", bus.insn_valid, 1'b0);
    check("rst_insn_addr", bus.insn_addr, 0);
    check("rst_insn_data", bus.insn_data, 0);
    check("rst_resp_err", bus.resp_err, 1'b0);
    @(negedge clk);
    bus.pc_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 100);
    for (int ph = 0; ph < 8; ph++) begin
      case (ph % 4)
        0: pct = 100;
        1: pct = 20;
        2: pct = 0;
        default: pct = 70;
      endcase
      for (int i = 0; i < 200; i++)
        step($urandom_range(0, 3) != 0,
             $urandom_range(0, 19) == 0, 1'b0, pct);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 100);

    for (int i = 0; i < 300; i++) begin
      if (mq.size() == 0 && rdy.size() == 0) break;
      step(1'b0, 1'b0, 1'b0, 100);
    end
    check("drain_mem", mq.size(), 0);
    check("drain_drop", drop, 0);
    check("drain_ring", rdy.size(), 0);

    step(1'b0, 1'b0, 1'b1, 100);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 100);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rerst_resp_err", bus.resp_err, 1'b0);
    check("rerst_insn_valid", bus.insn_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0, 100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
